mcfly_fetch_seq: RTL and testbench

MCFLY_FETCH_SEQ -- requirements
Module: mcfly_fetch_seq

---
 rtl/mcfly_fetch_seq.sv | 116 +++++++++++
 tb/tb_mcfly_fetch_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcfly_fetch_seq.sv
// Byte-serial instruction fetch sequencer: assembles little-endian 32-bit words and hands them to a consumer.
// Optional illegal-opcode trap state enabled by defining MCFLY_ILLEGAL_TRAP_EN.
module mcfly_fetch_seq #(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                mem_req,
   output logic [PC_WIDTH-1:0] mem_addr,
   input  logic                mem_ack,
   input  logic [7:0]          mem_data,
   output logic [31:0]         instr,
   output logic [PC_WIDTH-1:0] instr_pc,
   output logic [2:0]          instr_type,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                busy,
   output logic                illegal
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, TRAP} state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [1:0]          beat_q, beat_d;
   logic [31:0]         instr_q, instr_d;

   function automatic logic [2:0] decode_type(input logic [6:0] op);
      case (op)
         7'b0110011:             return 3'd0;
         7'b0000011, 7'b0010011: return 3'd1;
         7'b0100011:             return 3'd2;
         7'b1100011:             return 3'd3;
         7'b0010111:             return 3'd4;
         7'b1100111, 7'b1101111: return 3'd5;
         default:                return 3'd7;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         beat_q  <= 2'd0;
         instr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         beat_q  <= beat_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      beat_d  = beat_q;
      instr_d = instr_q;
      if (redirect && state_q != IDLE) begin
         // Redirect wins over everything; a half-built word is simply abandoned.
         pc_d    = redirect_pc & ~PC_WIDTH'(3);
         beat_d  = 2'd0;
         state_d = FETCH;
      end else begin
         case (state_q)
            IDLE: begin
               beat_d  = 2'd0;
               state_d = FETCH;
            end
            FETCH: begin
               if (mem_ack) begin
                  instr_d[{beat_q, 3'b000} +: 8] = mem_data;
                  beat_d = beat_q + 2'd1;
                  if (beat_q == 2'd3) begin
                     state_d = ISSUE;
`ifdef MCFLY_ILLEGAL_TRAP_EN
                     // Opcode byte arrived in beat 0, so it is already in instr_q.
                     if (decode_type(instr_q[6:0]) == 3'd7)
                        state_d = TRAP;
`endif
                  end
               end
            end
            ISSUE: begin
               if (instr_ready) begin
                  pc_d    = pc_q + PC_WIDTH'(4);
                  state_d = FETCH;
               end
            end
            TRAP: begin
               state_d = TRAP;
            end
         endcase
      end
   end

   always_comb begin
      mem_req     = (state_q == FETCH);
      busy        = (state_q == FETCH);
      mem_addr    = pc_q + PC_WIDTH'(beat_q);
      instr_valid = (state_q == ISSUE);
`ifdef MCFLY_ILLEGAL_TRAP_EN
      illegal     = (state_q == TRAP);
`else
      illegal     = 1'b0;
`endif
   end

   assign instr      = instr_q;
   assign instr_pc   = pc_q;
   assign instr_type = decode_type(instr_q[6:0]);

endmodule

// File: tb/tb_mcfly_fetch_seq.sv
// Testbench for mcfly_fetch_seq: directed timing checks plus randomized redirect episodes,
// with an instruction-stream scoreboard drained by an independent monitor.
module tb_mcfly_fetch_seq;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mem_req;
   logic [PW-1:0] mem_addr;
   logic          mem_ack = 1'b0;
   logic [7:0]    mem_data;
   logic [31:0]   instr;
   logic [PW-1:0] instr_pc;
   logic [2:0]    instr_type;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic          redirect = 1'b0;
   logic [PW-1:0] redirect_pc = '0;
   logic          busy;
   logic          illegal;

   logic [7:0] mem [0:65535];
   logic [7:0] legal_ops [0:7];
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] word;
      logic [2:0]  typ;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   assign mem_data = mem[mem_addr];

   mcfly_fetch_seq #(.PC_WIDTH(PW), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc), .instr_type(instr_type),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .busy(busy), .illegal(illegal)
   );

   function automatic logic [2:0] ref_type(input logic [6:0] op);
      if (op == 7'h33) return 3'd0;
      if (op == 7'h03 || op == 7'h13) return 3'd1;
      if (op == 7'h23) return 3'd2;
      if (op == 7'h63) return 3'd3;
      if (op == 7'h17) return 3'd4;
      if (op == 7'h67 || op == 7'h6F) return 3'd5;
      return 3'd7;
   endfunction

   // The instruction at a given pc is just the four memory bytes there, little-endian.
   function automatic exp_t ref_item(input logic [15:0] pc);
      exp_t e;
      logic [15:0] a;
      a      = pc & 16'hFFFC;
      e.pc   = a;
      e.word = {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
      e.typ  = ref_type(e.word[6:0]);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int bound, input string name);
      int k;
      k = 0;
      while (!instr_valid && k < bound) begin
         step();
         k++;
      end
      if (!instr_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: instr_valid still 0 after %0d cycles, expected 1", name, bound);
      end
   endtask

   task automatic issue_one(input logic [15:0] pc);
      sb_q.push_back(ref_item(pc));
      instr_ready = 1'b1;
      mem_ack     = 1'b1;
      wait_valid(40, "issue");
      step();
      instr_ready = 1'b0;
   endtask

   task automatic do_redirect(input logic [15:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      step();
      redirect    = 1'b0;
   endtask

   // Monitor: every accepted transfer must match the head of the expected stream.
   always @(negedge clk) begin
      exp_t e;
      if (rst && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_issue: pc 0x%0h word 0x%0h, no instruction expected", instr_pc, instr);
         end else begin
            e = sb_q.pop_front();
            check("issue_pc", 32'(instr_pc), 32'(e.pc));
            check("issue_word", instr, e.word);
            check("issue_type", 32'(instr_type), 32'(e.typ));
            check("issue_illegal", 32'(illegal), 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] prev_next, r, base;
      int n, k;
      bit same;
      legal_ops[0] = 8'h33; legal_ops[1] = 8'h03; legal_ops[2] = 8'h13; legal_ops[3] = 8'h23;
      legal_ops[4] = 8'h63; legal_ops[5] = 8'h17; legal_ops[6] = 8'h67; legal_ops[7] = 8'h6F;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 65536; i += 4) begin
`ifdef MCFLY_ILLEGAL_TRAP_EN
         mem[i] = legal_ops[$urandom_range(0, 7)];
`else
         if ($urandom_range(0, 1) == 1) mem[i] = legal_ops[$urandom_range(0, 7)];
`endif
      end
      mem[0] = 8'h33; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
      mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h10; mem[7] = 8'h00;
      mem[16'h0300] = 8'h7F;

      mem_ack = 1'b1;
      instr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);

      // First word after reset release, then back-to-back throughput.
      sb_q.push_back(ref_item(16'h0000));
      sb_q.push_back(ref_item(16'h0004));
      rst = 1'b1;
      check("idle_mem_req", 32'(mem_req), 32'd0);
      step();
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", 32'(mem_addr), 32'h0000);
      check("first_busy", 32'(busy), 32'd1);
      repeat (3) step();
      check("cyc5_valid", 32'(instr_valid), 32'd0);
      step();
      check("cyc6_valid", 32'(instr_valid), 32'd1);
      check("cyc6_instr", instr, 32'h00000533);
      check("cyc6_type", 32'(instr_type), 32'd0);
      check("cyc6_pc", 32'(instr_pc), 32'h0000);
      step();
      check("next_addr", 32'(mem_addr), 32'h0004);
      repeat (4) step();
      check("cyc11_valid", 32'(instr_valid), 32'd1);
      check("cyc11_pc", 32'(instr_pc), 32'h0004);
      step();
      instr_ready = 1'b0;

      // Memory stall during beat 2.
      do_redirect(16'h0200);
      check("stall_b0_addr", 32'(mem_addr), 32'h0200);
      step();
      step();
      mem_ack = 1'b0;
      check("stall_addr0", 32'(mem_addr), 32'h0202);
      repeat (2) begin
         step();
         check("stall_addr", 32'(mem_addr), 32'h0202);
         check("stall_req", 32'(mem_req), 32'd1);
      end
      step();
      mem_ack = 1'b1;
      check("stall_addr_last", 32'(mem_addr), 32'h0202);
      step();
      check("stall_valid_early", 32'(instr_valid), 32'd0);
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);

      // Consumer back-pressure in ISSUE.
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(instr_valid), 32'd1);
         check("hold_instr", instr, ref_item(16'h0200).word);
         check("hold_pc", 32'(instr_pc), 32'h0200);
         check("hold_req", 32'(mem_req), 32'd0);
         step();
      end
      issue_one(16'h0200);
      check("after_hold_addr", 32'(mem_addr), 32'h0204);

      // Redirect during beat 1 discards the partial word.
      step();
      check("b1_addr", 32'(mem_addr), 32'h0205);
      do_redirect(16'h0102);
      check("redir_addr", 32'(mem_addr), 32'h0100);
      check("redir_req", 32'(mem_req), 32'd1);
      issue_one(16'h0100);

      // Unknown opcode 0x7F.
      do_redirect(16'h0300);
`ifdef MCFLY_ILLEGAL_TRAP_EN
      repeat (8) step();
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_valid", 32'(instr_valid), 32'd0);
      check("trap_req", 32'(mem_req), 32'd0);
      do_redirect(16'h0304);
      check("trap_exit_illegal", 32'(illegal), 32'd0);
      check("trap_exit_addr", 32'(mem_addr), 32'h0304);
`else
      sb_q.push_back(ref_item(16'h0300));
      wait_valid(40, "unknown_op");
      check("unknown_type", 32'(instr_type), 32'd7);
      check("unknown_illegal", 32'(illegal), 32'd0);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
`endif
      mem[16'h0300] = 8'h13;

      // PC wrap at the top of the address space, then reset mid-fetch.
      do_redirect(16'hFFFE);
      check("wrap_start_addr", 32'(mem_addr), 32'hFFFC);
      issue_one(16'hFFFC);
      check("wrap_addr", 32'(mem_addr), 32'h0000);
      check("wrap_req", 32'(mem_req), 32'd1);
      step();
      step();
      check("b2_addr", 32'(mem_addr), 32'h0002);
      rst = 1'b0;
      #1;
      check("async_rst_req", 32'(mem_req), 32'd0);
      check("async_rst_valid", 32'(instr_valid), 32'd0);
      check("async_rst_instr", instr, 32'd0);
      check("async_rst_pc", 32'(instr_pc), 32'h0000);
      repeat (2) step();
      rst = 1'b1;
      check("rerelease_idle_req", 32'(mem_req), 32'd0);
      step();
      check("rerelease_req", 32'(mem_req), 32'd1);
      check("rerelease_addr", 32'(mem_addr), 32'h0000);
      issue_one(16'h0000);
      prev_next = 16'h0004;

      // Randomized episodes: redirect somewhere, drain N instructions under random handshakes.
      for (int ep = 0; ep < 40; ep++) begin
         r    = 16'($urandom);
         n    = $urandom_range(1, 4);
         same = ($urandom_range(0, 2) == 0);
         if (same) begin
            sb_q.push_back(ref_item(prev_next));
            instr_ready = 1'b1;
            mem_ack     = 1'b1;
            wait_valid(40, "pre_redirect");
            redirect    = 1'b1;
            redirect_pc = r;
            step();
            redirect    = 1'b0;
            instr_ready = 1'b0;
         end else begin
            instr_ready = 1'b0;
            do_redirect(r);
         end
         base = r & 16'hFFFC;
         for (int j = 0; j < n; j++) sb_q.push_back(ref_item(base + 16'(4 * j)));
         k = 0;
         while (sb_q.size() != 0 && k < 300) begin
            mem_ack     = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            step();
            k++;
         end
         instr_ready = 1'b0;
         if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL episode_timeout: %0d instructions outstanding, expected 0", sb_q.size());
            sb_q.delete();
         end
         prev_next = base + 16'(4 * n);
         repeat ($urandom_range(0, 6)) begin
            mem_ack = 1'($urandom_range(0, 1));
            step();
         end
      end

      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
